// File: rtl/alu_pkg.sv
// Shared definitions for the ALU writeback slice.
// Holds the datapath widths, the status flag bit positions and the packed
// entry type that travels through the writeback skid FIFO.
package alu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned NREG   = 8;
    localparam int unsigned ADDR_W = 3;

    // Flag bit positions within a status word {V,C,S,Z}.
    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_S = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 3;

    typedef struct packed {
        logic              flag_we;
        logic [ADDR_W-1:0] rd;
        logic [FLAG_W-1:0] flags;
        logic [DATA_W-1:0] result;
    } wb_entry_t;

endpackage

// File: rtl/alu_writeback_if.sv
// ALU-to-writeback result handshake.
// Signals: valid/ready handshake, result, flags, rd (destination index),
// flag_we (update status register on commit).
// master: ALU side (drives valid and payload); slave: writeback side (drives ready).
interface alu_writeback_if;
    import alu_pkg::*;

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] result;
    logic [FLAG_W-1:0] flags;
    logic [ADDR_W-1:0] rd;
    logic              flag_we;

    modport master (
        output valid, result, flags, rd, flag_we,
        input  ready
    );

    modport slave (
        input  valid, result, flags, rd, flag_we,
        output ready
    );

endinterface

// File: rtl/wb_fifo2.sv
// Two-entry FIFO for writeback entries.
// Ports: clk, rst (async, active-high), push/push_data, pop, count (0..2),
// slot0 (head, oldest) and slot1 (second entry, valid when count == 2).
// The caller must only push when count != 2 and only pop when count != 0.
module wb_fifo2
    import alu_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t push_data,
    input  logic      pop,
    output logic [1:0] count,
    output wb_entry_t slot0,
    output wb_entry_t slot1
);

    wb_entry_t  slots_q [2];
    wb_entry_t  slots_d [2];
    logic [1:0] count_q, count_d;
    logic [1:0] wr_pos;

    // Shift organisation: slot 0 is always the head, so a pop moves slot 1
    // down and a simultaneous push lands behind whatever remains.
    always_comb begin
        slots_d[0] = slots_q[0];
        slots_d[1] = slots_q[1];
        wr_pos     = count_q - {1'b0, pop};
        if (pop) begin
            slots_d[0] = slots_q[1];
        end
        if (push) begin
            slots_d[wr_pos[0]] = push_data;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slots_q[0] <= '0;
            slots_q[1] <= '0;
            count_q    <= 2'd0;
        end else begin
            slots_q[0] <= slots_d[0];
            slots_q[1] <= slots_d[1];
            count_q    <= count_d;
        end
    end

    assign count = count_q;
    assign slot0 = slots_q[0];
    assign slot1 = slots_q[1];

endmodule

// File: rtl/alu_writeback.sv
// Writeback stage behind the 8-bit ADD/SUB datapath.
// Accepts results over in_bus (alu_writeback_if.slave), buffers up to two in
// a skid FIFO and commits one per cycle (unless wb_stall) into an 8x8 register
// file and the status register.
// Ports: clk, rst (async, active-high), in_bus, wb_stall, clr_v,
// rd_addr_a/b -> rd_data_a/b (forwarded reads), status_reg, wb_commit,
// wb_commit_rd, pending (FIFO occupancy).
// Macro STICKY_V_EN: makes status bit V sticky until cleared by clr_v.
module alu_writeback
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    alu_writeback_if.slave    in_bus,
    input  logic              wb_stall,
    input  logic              clr_v,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [FLAG_W-1:0] status_reg,
    output logic              wb_commit,
    output logic [ADDR_W-1:0] wb_commit_rd,
    output logic [1:0]        pending
);

    logic [1:0]        count;
    wb_entry_t         slot0, slot1, push_data;
    logic              push, pop;
    logic [DATA_W-1:0] regs_q [NREG];
    logic [FLAG_W-1:0] status_q, status_d;
    logic              commit_q;
    logic [ADDR_W-1:0] commit_rd_q;

    // Ready depends only on registered occupancy (and reset), never on stall.
    assign in_bus.ready = !rst && (count != 2'd2);
    assign push         = in_bus.valid && in_bus.ready;
    assign pop          = (count != 2'd0) && !wb_stall;

    always_comb begin
        push_data         = '0;
        push_data.result  = in_bus.result;
        push_data.flags   = in_bus.flags;
        push_data.rd      = in_bus.rd;
        push_data.flag_we = in_bus.flag_we;
    end

    wb_fifo2 u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .count     (count),
        .slot0     (slot0),
        .slot1     (slot1)
    );

    // Youngest matching pending entry wins, so slot1 is checked last.
    always_comb begin
        rd_data_a = regs_q[rd_addr_a];
        if (count != 2'd0 && slot0.rd == rd_addr_a) rd_data_a = slot0.result;
        if (count == 2'd2 && slot1.rd == rd_addr_a) rd_data_a = slot1.result;
        rd_data_b = regs_q[rd_addr_b];
        if (count != 2'd0 && slot0.rd == rd_addr_b) rd_data_b = slot0.result;
        if (count == 2'd2 && slot1.rd == rd_addr_b) rd_data_b = slot1.result;
    end

`ifdef STICKY_V_EN
    // A committing V=1 overrides a simultaneous clear.
    always_comb begin
        status_d = status_q;
        if (clr_v) status_d[FLAG_V] = 1'b0;
        if (pop && slot0.flag_we) begin
            status_d[FLAG_V-1:0] = slot0.flags[FLAG_V-1:0];
            status_d[FLAG_V]     = status_d[FLAG_V] | slot0.flags[FLAG_V];
        end
    end
`else
    logic unused_clr_v;
    assign unused_clr_v = clr_v;

    always_comb begin
        status_d = status_q;
        if (pop && slot0.flag_we) status_d = slot0.flags;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            status_q    <= '0;
            commit_q    <= 1'b0;
            commit_rd_q <= '0;
        end else begin
            if (pop) begin
                regs_q[slot0.rd] <= slot0.result;
                commit_rd_q      <= slot0.rd;
            end
            status_q <= status_d;
            commit_q <= pop;
        end
    end

    assign status_reg   = status_q;
    assign wb_commit    = commit_q;
    assign wb_commit_rd = commit_rd_q;
    assign pending      = count;

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed vector table, reset
// sequence, then random traffic compared against a queue-based model.
module tb_alu_writeback;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wb_stall = 1'b0;
    logic clr_v = 1'b0;
    logic [2:0] rd_addr_a = '0, rd_addr_b = '0;
    logic [7:0] rd_data_a, rd_data_b;
    logic [3:0] status_reg;
    logic       wb_commit;
    logic [2:0] wb_commit_rd;
    logic [1:0] pending;

    alu_writeback_if bus ();

    alu_writeback dut (
        .clk          (clk),
        .rst          (rst),
        .in_bus       (bus),
        .wb_stall     (wb_stall),
        .clr_v        (clr_v),
        .rd_addr_a    (rd_addr_a),
        .rd_addr_b    (rd_addr_b),
        .rd_data_a    (rd_data_a),
        .rd_data_b    (rd_data_b),
        .status_reg   (status_reg),
        .wb_commit    (wb_commit),
        .wb_commit_rd (wb_commit_rd),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] result;
        logic [3:0] flags;
        logic [2:0] rd;
        logic       we;
    } ment_t;

    ment_t      mq[$];
    logic [7:0] mregs [8];
    logic [3:0] mstat;
    logic       mcommit;
    logic [2:0] mcrd;

    task automatic m_reset();
        mq.delete();
        for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
        mstat = 4'h0; mcommit = 1'b0; mcrd = 3'd0;
    endtask

    function automatic logic [7:0] m_read(input logic [2:0] a);
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].rd == a) return mq[i].result;
        return mregs[a];
    endfunction

    task automatic m_check();
        chk("m_ready", bus.ready, (mq.size() < 2) ? 1 : 0);
        chk("m_pending", pending, mq.size());
        chk("m_data_a", rd_data_a, m_read(rd_addr_a));
        chk("m_data_b", rd_data_b, m_read(rd_addr_b));
        chk("m_status", status_reg, mstat);
        chk("m_commit", wb_commit, mcommit);
        if (mcommit) chk("m_commit_rd", wb_commit_rd, mcrd);
    endtask

    // Called just after a rising edge with the inputs that were sampled there.
    task automatic m_edge();
        bit    can_push = (mq.size() < 2);
        ment_t e;
        mcommit = 1'b0;
`ifdef STICKY_V_EN
        if (clr_v) mstat[3] = 1'b0;
`endif
        if (mq.size() > 0 && !wb_stall) begin
            e = mq.pop_front();
            mregs[e.rd] = e.result;
            if (e.we) begin
`ifdef STICKY_V_EN
                mstat = {mstat[3] | e.flags[3], e.flags[2:0]};
`else
                mstat = e.flags;
`endif
            end
            mcommit = 1'b1;
            mcrd    = e.rd;
        end
        if (bus.valid && can_push) begin
            e.result = bus.result; e.flags = bus.flags; e.rd = bus.rd; e.we = bus.flag_we;
            mq.push_back(e);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] res, input logic [3:0] fl,
                         input logic [2:0] rd, input logic we, input logic st,
                         input logic cv, input logic [2:0] aa, input logic [2:0] ab);
        bus.valid = v; bus.result = res; bus.flags = fl; bus.rd = rd; bus.flag_we = we;
        wb_stall = st; clr_v = cv; rd_addr_a = aa; rd_addr_b = ab;
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       v;
        logic [7:0] res;
        logic [3:0] fl;
        logic [2:0] rd;
        logic       we, st, cv;
        logic [2:0] aa;
        logic       e_ready;
        logic [1:0] e_pend;
        logic [7:0] e_data;
        logic [3:0] e_stat;
        logic       e_commit;
        logic [2:0] e_crd;
    } vec_t;

`ifdef STICKY_V_EN
    localparam logic [3:0] STAT_AFTER_VZ = 4'b1001;
`else
    localparam logic [3:0] STAT_AFTER_VZ = 4'b0001;
`endif

    function automatic vec_t mk(input logic v, input logic [7:0] res, input logic [3:0] fl,
                                input logic [2:0] rd, input logic we, input logic st,
                                input logic cv, input logic [2:0] aa, input logic er,
                                input logic [1:0] ep, input logic [7:0] ed,
                                input logic [3:0] es, input logic ec, input logic [2:0] ecr);
        vec_t t;
        t.v = v; t.res = res; t.fl = fl; t.rd = rd; t.we = we; t.st = st; t.cv = cv;
        t.aa = aa; t.e_ready = er; t.e_pend = ep; t.e_data = ed; t.e_stat = es;
        t.e_commit = ec; t.e_crd = ecr;
        return t;
    endfunction

    vec_t vt[$];

    initial begin
        logic [2:0] ab_rand;
        m_reset();
        drive(0, 8'h00, 4'h0, 3'd0, 0, 0, 0, 3'd0, 3'd0);

        // Reset state while rst is held.
        #2;
        chk("rst_ready", bus.ready, 0);
        chk("rst_pending", pending, 0);
        chk("rst_commit", wb_commit, 0);
        chk("rst_crd", wb_commit_rd, 0);
        chk("rst_status", status_reg, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_ready", bus.ready, 1);
        chk("rel_data_a", rd_data_a, 0);

        //          v  res    fl     rd  we st cv aa | rdy pend data  stat   cm crd
        vt.push_back(mk(1, 8'h3C, 4'h0, 3'd5, 1, 0, 0, 3'd5, 1, 2'd0, 8'h00, 4'h0, 0, 3'd0));
        vt.push_back(mk(0, 8'h00, 4'h0, 3'd0, 0, 0, 0, 3'd5, 1, 2'd1, 8'h3C, 4'h0, 0, 3'd0));
        vt.push_back(mk(0, 8'h00, 4'h0, 3'd0, 0, 0, 0, 3'd5, 1, 2'd0, 8'h3C, 4'h0, 1, 3'd5));
        vt.push_back(mk(0, 8'h00, 4'h0, 3'd0, 0, 0, 0, 3'd5, 1, 2'd0, 8'h3C, 4'h0, 0, 3'd0));
        vt.push_back(mk(1, 8'h11, 4'h0, 3'd1, 0, 1, 0, 3'd1, 1, 2'd0, 8'h00, 4'h0, 0, 3'd0));
        vt.push_back(mk(1, 8'h22, 4'h0, 3'd1, 0, 1, 0, 3'd1, 1, 2'd1, 8'h11, 4'h0, 0, 3'd0));
        vt.push_back(mk(1, 8'h33, 4'h0, 3'd2, 0, 1, 0, 3'd1, 0, 2'd2, 8'h22, 4'h0, 0, 3'd0));
        vt.push_back(mk(0, 8'h00, 4'h0, 3'd0, 0, 0, 0, 3'd1, 0, 2'd2, 8'h22, 4'h0, 0, 3'd0));
        vt.push_back(mk(0, 8'h00, 4'h0, 3'd0, 0, 0, 0, 3'd1, 1, 2'd1, 8'h22, 4'h0, 1, 3'd1));
        vt.push_back(mk(0, 8'h00, 4'h0, 3'd0, 0, 0, 0, 3'd1, 1, 2'd0, 8'h22, 4'h0, 1, 3'd1));
        vt.push_back(mk(1, 8'h80, 4'h8, 3'd3, 1, 0, 0, 3'd3, 1, 2'd0, 8'h00, 4'h0, 0, 3'd0));
        vt.push_back(mk(1, 8'h01, 4'h1, 3'd4, 1, 0, 0, 3'd3, 1, 2'd1, 8'h80, 4'h0, 0, 3'd0));
        vt.push_back(mk(0, 8'h00, 4'h0, 3'd0, 0, 0, 0, 3'd4, 1, 2'd1, 8'h01, 4'h8, 1, 3'd3));
        vt.push_back(mk(0, 8'h00, 4'h0, 3'd0, 0, 0, 1, 3'd4, 1, 2'd0, 8'h01, STAT_AFTER_VZ,
                        1, 3'd4));
        vt.push_back(mk(1, 8'h5A, 4'hF, 3'd6, 0, 0, 0, 3'd6, 1, 2'd0, 8'h00, 4'h1, 0, 3'd0));
        vt.push_back(mk(0, 8'h00, 4'h0, 3'd0, 0, 0, 0, 3'd6, 1, 2'd1, 8'h5A, 4'h1, 0, 3'd0));
        vt.push_back(mk(0, 8'h00, 4'h0, 3'd0, 0, 0, 0, 3'd6, 1, 2'd0, 8'h5A, 4'h1, 1, 3'd6));
        vt.push_back(mk(1, 8'hA0, 4'h0, 3'd7, 0, 0, 0, 3'd7, 1, 2'd0, 8'h00, 4'h1, 0, 3'd0));
        vt.push_back(mk(1, 8'hA1, 4'h0, 3'd7, 0, 0, 0, 3'd7, 1, 2'd1, 8'hA0, 4'h1, 0, 3'd0));
        vt.push_back(mk(1, 8'hA2, 4'h0, 3'd7, 0, 0, 0, 3'd7, 1, 2'd1, 8'hA1, 4'h1, 1, 3'd7));
        vt.push_back(mk(1, 8'hA3, 4'h0, 3'd7, 0, 0, 0, 3'd7, 1, 2'd1, 8'hA2, 4'h1, 1, 3'd7));
        vt.push_back(mk(0, 8'h00, 4'h0, 3'd0, 0, 0, 0, 3'd7, 1, 2'd1, 8'hA3, 4'h1, 1, 3'd7));
        vt.push_back(mk(0, 8'h00, 4'h0, 3'd0, 0, 0, 0, 3'd7, 1, 2'd0, 8'hA3, 4'h1, 1, 3'd7));

        @(negedge clk);
        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].v, vt[i].res, vt[i].fl, vt[i].rd, vt[i].we, vt[i].st, vt[i].cv,
                  vt[i].aa, 3'd5);
            #1;
            chk($sformatf("v%0d_ready", i), bus.ready, vt[i].e_ready);
            chk($sformatf("v%0d_pending", i), pending, vt[i].e_pend);
            chk($sformatf("v%0d_data_a", i), rd_data_a, vt[i].e_data);
            chk($sformatf("v%0d_status", i), status_reg, vt[i].e_stat);
            chk($sformatf("v%0d_commit", i), wb_commit, vt[i].e_commit);
            if (vt[i].e_commit) chk($sformatf("v%0d_crd", i), wb_commit_rd, vt[i].e_crd);
            m_check();
            finish_cycle();
        end

        // Reset with two entries pending: nothing commits, everything clears.
        drive(1, 8'h77, 4'hF, 3'd2, 1, 1, 0, 3'd2, 3'd5);
        finish_cycle();
        drive(1, 8'h66, 4'hF, 3'd5, 1, 1, 0, 3'd2, 3'd5);
        finish_cycle();
        drive(0, 8'h00, 4'h0, 3'd0, 0, 1, 0, 3'd2, 3'd5);
        #1;
        chk("pre_rst_pending", pending, 2);
        chk("pre_rst_ready", bus.ready, 0);
        #1 rst = 1'b1;
        #1;
        m_reset();
        chk("mid_rst_pending", pending, 0);
        chk("mid_rst_ready", bus.ready, 0);
        chk("mid_rst_data_a", rd_data_a, 0);
        chk("mid_rst_data_b", rd_data_b, 0);
        chk("mid_rst_status", status_reg, 0);
        chk("mid_rst_commit", wb_commit, 0);
        @(negedge clk);
        wb_stall = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_rst_ready", bus.ready, 1);
        for (int a = 0; a < 8; a++) begin
            rd_addr_a = 3'(a);
            #1;
            chk($sformatf("post_rst_reg%0d", a), rd_data_a, 0);
        end
        @(negedge clk);
        #1;
        chk("post_rst_no_commit", wb_commit, 0);
        chk("post_rst_pending", pending, 0);
        @(negedge clk);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            ab_rand = 3'($urandom_range(0, 7));
            drive(1'($urandom_range(0, 99) < 70), 8'($urandom), 4'($urandom),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 99) < 30), 1'($urandom_range(0, 99) < 10),
                  3'($urandom_range(0, 7)), ab_rand);
            #1;
            m_check();
            finish_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
